// File: rtl/sub2b_seq_if.sv
// ---------------------------------------------------------------------------
// sub2b_seq_if
// Purpose : Bundles the operand/handshake signals of the sequential 2-bit
//           slice subtractor so a controller and the datapath share one port.
// Signals : start  - launch request from the controller
//           x, y   - minuend and subtrahend, W bits
//           bi     - borrow in
//           busy   - subtractor is stepping through slices
//           done   - one-cycle pulse, z/bo valid from this cycle
//           z      - difference modulo 2^W
//           bo     - borrow out
// Modports: master - the controller issuing operations
//           slave  - the subtractor itself
// ---------------------------------------------------------------------------
interface sub2b_seq_if #(
   parameter int W = 8
) ();

   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] z;
   logic         bo;

   modport master (
      output start, x, y, bi,
      input  busy, done, z, bo
   );

   modport slave (
      input  start, x, y, bi,
      output busy, done, z, bo
   );

endinterface

// File: rtl/sub2b_seq.sv
// ---------------------------------------------------------------------------
// sub2b_seq
// Purpose : Multi-cycle ripple subtractor computing z = x - y - bi two bits
//           per clock through a single 2-bit borrow slice. Each slice forms
//           x + ~y + carry with two full-adder cells; the internal carry is
//           the inverted borrow, so it starts as ~bi and bo is ~final carry.
// Params  : W     - operand width, even and >= 2; W/2 slice cycles per op
// Ports   : clk   - rising-edge clock
//           rst   - synchronous active-high reset, aborts any operation
//           bus   - sub2b_seq_if.slave (start, x, y, bi in; busy, done,
//                   z, bo out)
// ---------------------------------------------------------------------------
module sub2b_seq #(
   parameter int W = 8
) (
   input  logic        clk,
   input  logic        rst,
   sub2b_seq_if.slave  bus
);

   localparam int            NSLICE = W / 2;
   localparam int            CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  opX_q, opX_d;
   logic [W-1:0]  opY_q, opY_d;
   logic [W-1:0]  z_q, z_d;
   logic          carry_q, carry_d;
   logic          bo_q, bo_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [1:0]    sliceX;
   logic [1:0]    sliceY;
   logic [1:0]    sliceSum;
   logic          midCarry;
   logic          sliceCarry;

   // The shared full-adder cell: returns {carry out, sum}.
   function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic cin);
      return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
   endfunction

   // The 2-bit slice: picks bits 2*cnt+1:2*cnt of the latched operands and
   // ripples x + ~y + carry through two full adders. The carry out of the
   // top bit is the "no borrow" flag fed to the next slice.
   always_comb begin
      sliceX   = opX_q[{cnt_q, 1'b0} +: 2];
      sliceY   = opY_q[{cnt_q, 1'b0} +: 2];
      sliceSum = 2'b00;
      {midCarry, sliceSum[0]}   = fullAdd(sliceX[0], ~sliceY[0], carry_q);
      {sliceCarry, sliceSum[1]} = fullAdd(sliceX[1], ~sliceY[1], midCarry);
   end

   // Next-state logic. IDLE and DONE both accept a new operation, which is
   // what allows back-to-back issue straight out of the done cycle. Starts
   // seen while in RUN fall through untouched so latched operands are safe.
   // Only the z bits of the current slice are rewritten; the rest hold.
   always_comb begin
      state_d = state_q;
      opX_d   = opX_q;
      opY_d   = opY_q;
      z_d     = z_q;
      carry_d = carry_q;
      bo_d    = bo_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               opX_d   = bus.x;
               opY_d   = bus.y;
               carry_d = ~bus.bi;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            z_d[{cnt_q, 1'b0} +: 2] = sliceSum;
            carry_d                 = sliceCarry;
            cnt_d                   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               bo_d    = ~sliceCarry;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset wins over everything and clears
   // the visible result so an aborted operation leaves no stale answer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opX_q   <= '0;
         opY_q   <= '0;
         z_q     <= '0;
         carry_q <= 1'b0;
         bo_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opX_q   <= opX_d;
         opY_q   <= opY_d;
         z_q     <= z_d;
         carry_q <= carry_d;
         bo_q    <= bo_d;
         cnt_q   <= cnt_d;
      end
   end

   // Status decodes straight from the registered state, so busy and done
   // are glitch-free and done lasts exactly the one DONE cycle.
   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.z    = z_q;
   assign bus.bo   = bo_q;

endmodule

// File: tb/tb_sub2b_seq.sv
// ---------------------------------------------------------------------------
// tb_sub2b_seq
// Purpose : Self-checking bench for sub2b_seq. A W=8 instance gets directed
//           vectors with hand-computed answers plus handshake corner cases;
//           a W=2 instance is swept over every x, y, bi combination.
// ---------------------------------------------------------------------------
module tb_sub2b_seq;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       bi;
      logic [8:0] exp;
   } vec_t;

   logic clk;
   logic rst;

   int checks;
   int errors;

   logic [8:0] expQ8[$];
   logic [2:0] expQ2[$];

   sub2b_seq_if #(.W(8)) if8 ();
   sub2b_seq_if #(.W(2)) if2 ();

   sub2b_seq #(.W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   sub2b_seq #(.W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something stalls beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   // Single comparison point: every check steps the shared counters.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the W=8 instance: every done pulse must match the oldest
   // outstanding expectation; a done with nothing queued is an extra pulse.
   always @(negedge clk) begin
      if (!rst && if8.done) begin
         if (expQ8.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done8Unexpected got z=%0d bo=%0d expected no done", if8.z, if8.bo);
         end else begin
            checkOutput("result8", {23'd0, if8.bo, if8.z}, {23'd0, expQ8.pop_front()});
         end
      end
   end

   // Monitor for the W=2 instance, same scheme.
   always @(negedge clk) begin
      if (!rst && if2.done) begin
         if (expQ2.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done2Unexpected got z=%0d bo=%0d expected no done", if2.z, if2.bo);
         end else begin
            checkOutput("result2", {29'd0, if2.bo, if2.z}, {29'd0, expQ2.pop_front()});
         end
      end
   end

   // Present one W=8 operation for a single accepting edge, then scramble
   // the inputs so any late sampling shows up as a wrong result.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [8:0] exp, input bit doPush);
      if8.start = 1'b1;
      if8.x     = a;
      if8.y     = b;
      if8.bi    = c;
      if (doPush) expQ8.push_back(exp);
      @(posedge clk);
      #1;
      if8.start = 1'b0;
      if8.x     = 8'($urandom);
      if8.y     = 8'($urandom);
      if8.bi    = 1'($urandom);
   endtask

   // Count edges until done is seen on the W=8 instance, bounded.
   task automatic waitDone8(input int expLat, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!if8.done && n < 20);
      checkOutput(name, n, expLat);
   endtask

   vec_t vecs[5] = '{
      '{x: 8'd200, y: 8'd55, bi: 1'b0, exp: {1'b0, 8'd145}},
      '{x: 8'd3,   y: 8'd5,  bi: 1'b0, exp: {1'b1, 8'd254}},
      '{x: 8'd0,   y: 8'd0,  bi: 1'b1, exp: {1'b1, 8'hFF}},
      '{x: 8'd10,  y: 8'd10, bi: 1'b0, exp: {1'b0, 8'd0}},
      '{x: 8'd255, y: 8'd0,  bi: 1'b0, exp: {1'b0, 8'd255}}
   };

   // Main stimulus sequence.
   initial begin
      logic [2:0] exp2;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      if8.start = 1'b0;
      if8.x     = '0;
      if8.y     = '0;
      if8.bi    = 1'b0;
      if2.start = 1'b0;
      if2.x     = '0;
      if2.y     = '0;
      if2.bi    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetBusy8", {31'd0, if8.busy}, 32'd0);
      checkOutput("resetDone8", {31'd0, if8.done}, 32'd0);
      checkOutput("resetZ8",    {24'd0, if8.z},    32'd0);
      checkOutput("resetBo8",   {31'd0, if8.bo},   32'd0);
      checkOutput("resetBusy2", {31'd0, if2.busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].x, vecs[i].y, vecs[i].bi, vecs[i].exp, 1'b1);
         checkOutput("busyInRun", {31'd0, if8.busy}, 32'd1);
         waitDone8(4, "latency8");
         @(posedge clk);
         #1;
         checkOutput("doneOnePulse", {31'd0, if8.done}, 32'd0);
         checkOutput("zHeldAfterDone", {24'd0, if8.z}, {24'd0, vecs[i].exp[7:0]});
      end

      applyStimulus(8'd200, 8'd55, 1'b0, {1'b0, 8'd145}, 1'b1);
      if8.start = 1'b1;
      if8.x     = 8'd1;
      if8.y     = 8'd1;
      if8.bi    = 1'b0;
      @(posedge clk);
      #1;
      if8.start = 1'b0;
      checkOutput("busyAfterIgnoredStart", {31'd0, if8.busy}, 32'd1);
      waitDone8(3, "latencyIgnoredStart");
      repeat (6) @(posedge clk);
      #1;

      applyStimulus(8'd100, 8'd30, 1'b1, {1'b0, 8'd69}, 1'b1);
      waitDone8(4, "latencyFirstOfPair");
      applyStimulus(8'd7, 8'd9, 1'b1, {1'b1, 8'd253}, 1'b1);
      checkOutput("busyBackToBack", {31'd0, if8.busy}, 32'd1);
      waitDone8(4, "latencySecondOfPair");
      @(posedge clk);
      #1;

      applyStimulus(8'd50, 8'd20, 1'b0, 9'd0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortBusy", {31'd0, if8.busy}, 32'd0);
      checkOutput("abortDone", {31'd0, if8.done}, 32'd0);
      checkOutput("abortZ",    {24'd0, if8.z},    32'd0);
      checkOutput("abortBo",   {31'd0, if8.bo},   32'd0);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 2; c++) begin
               exp2 = 3'(a - b - c);
               if2.start = 1'b1;
               if2.x     = 2'(a);
               if2.y     = 2'(b);
               if2.bi    = 1'(c);
               expQ2.push_back(exp2);
               @(posedge clk);
               #1;
               if2.start = 1'b0;
               if2.x     = 2'($urandom);
               if2.y     = 2'($urandom);
               begin
                  int n;
                  n = 0;
                  do begin
                     @(posedge clk);
                     #1;
                     n++;
                  end while (!if2.done && n < 10);
                  checkOutput("latency2", n, 1);
               end
            end
         end
      end

      repeat (4) @(posedge clk);
      #1;
      checkOutput("pending8", expQ8.size(), 0);
      checkOutput("pending2", expQ2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
